// File: rtl/sw_array_ctrl.sv
// Sequencing controller for a linear chain of Smith-Waterman PEs: buffers a short read,
// broadcasts it with a single store token, streams the reference and tracks the best tail score.
module sw_array_ctrl #(
    parameter int N_PE      = 8,
    parameter int SCORE_W   = 10,
    parameter int REF_LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [REF_LEN_W-1:0] ref_len,
    output logic                 busy,
    input  logic [1:0]           rd_base,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [1:0]           ref_base,
    input  logic                 ref_valid,
    output logic                 ref_ready,
    output logic [1:0]           pe_S,
    output logic                 pe_store_S,
    output logic [1:0]           pe_T,
    output logic                 pe_init,
    output logic [SCORE_W-1:0]   pe_V,
    output logic [SCORE_W-1:0]   pe_F,
    input  logic [SCORE_W-1:0]   last_V,
    input  logic                 last_init,
    output logic                 done,
    output logic                 err,
    output logic [SCORE_W-1:0]   best_score,
    output logic [REF_LEN_W-1:0] best_pos
);

    localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam int TO_W  = $clog2(N_PE + 4) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        BCAST  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t               state;
    logic [1:0]           rd_buf [N_PE];
    logic [IDX_W-1:0]     ld_cnt;
    logic [IDX_W-1:0]     bc_cnt;
    logic [IDX_W-1:0]     bc_nxt;
    logic [REF_LEN_W-1:0] ref_len_q;
    logic [REF_LEN_W-1:0] len_m1;
    logic [REF_LEN_W-1:0] ref_cnt;
    logic [REF_LEN_W-1:0] res_cnt;
    logic [TO_W-1:0]      drain_cnt;
    logic                 track_en;
    logic                 result_done;

    // Unsigned, strict: a tie never moves best_pos away from the earliest hit.
    function automatic logic is_better(input logic [SCORE_W-1:0] cand,
                                       input logic [SCORE_W-1:0] cur);
        return cand > cur;
    endfunction

    // The array boundary row/column is always zero.
    assign pe_V = '0;
    assign pe_F = '0;

    assign len_m1      = ref_len_q - REF_LEN_W'(1);
    assign bc_nxt      = bc_cnt + IDX_W'(1);
    assign track_en    = (state == STREAM) || (state == DRAIN);
    assign result_done = (last_init && (res_cnt == len_m1)) || (res_cnt == ref_len_q);

    // Read buffer is pure data: no reset, contents are don't-care between jobs.
    always_ff @(posedge clk) begin
        if (state == LOAD && rd_valid) begin
            rd_buf[ld_cnt] <= rd_base;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            rd_ready   <= 1'b0;
            ref_ready  <= 1'b0;
            pe_S       <= '0;
            pe_store_S <= 1'b0;
            pe_T       <= '0;
            pe_init    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            best_score <= '0;
            best_pos   <= '0;
            ld_cnt     <= '0;
            bc_cnt     <= '0;
            ref_len_q  <= '0;
            ref_cnt    <= '0;
            res_cnt    <= '0;
            drain_cnt  <= '0;
        end else begin
            done <= 1'b0;

            // Results are taken whenever the tail flags them, not at a fixed offset.
            if (track_en && last_init) begin
                if (is_better(last_V, best_score)) begin
                    best_score <= last_V;
                    best_pos   <= res_cnt;
                end
                res_cnt <= res_cnt + REF_LEN_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        ref_len_q  <= ref_len;
                        best_score <= '0;
                        best_pos   <= '0;
                        err        <= 1'b0;
                        ld_cnt     <= '0;
                        bc_cnt     <= '0;
                        ref_cnt    <= '0;
                        res_cnt    <= '0;
                        drain_cnt  <= '0;
                        busy       <= 1'b1;
                        if (ref_len == '0) begin
                            state <= DONE;
                        end else begin
                            state    <= LOAD;
                            rd_ready <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (rd_valid) begin
                        ld_cnt <= ld_cnt + IDX_W'(1);
                        if (ld_cnt == IDX_W'(N_PE - 1)) begin
                            rd_ready   <= 1'b0;
                            pe_store_S <= 1'b1;
                            pe_S       <= (N_PE == 1) ? rd_base : rd_buf[0];
                            bc_cnt     <= '0;
                            state      <= BCAST;
                        end
                    end
                end

                // The token walks one PE per cycle, so S must advance in lockstep.
                BCAST: begin
                    pe_store_S <= 1'b0;
                    if (bc_cnt == IDX_W'(N_PE - 1)) begin
                        pe_S      <= '0;
                        ref_ready <= 1'b1;
                        state     <= STREAM;
                    end else begin
                        pe_S   <= rd_buf[bc_nxt];
                        bc_cnt <= bc_nxt;
                    end
                end

                STREAM: begin
                    if (ref_valid) begin
                        pe_T    <= ref_base;
                        pe_init <= 1'b1;
                        ref_cnt <= ref_cnt + REF_LEN_W'(1);
                        if (ref_cnt == len_m1) begin
                            ref_ready <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end else begin
                        // The chain cannot stall, so a bubble corrupts the job.
                        pe_T      <= '0;
                        pe_init   <= 1'b0;
                        ref_ready <= 1'b0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end

                DRAIN: begin
                    pe_T    <= '0;
                    pe_init <= 1'b0;
                    if (result_done) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (drain_cnt == TO_W'(N_PE + 3)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + TO_W'(1);
                    end
                end

                // Aborted/completed jobs enter with done already raised; the
                // zero-length path raises it here instead, one cycle later.
                DONE: begin
                    done  <= !done;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sw_array_ctrl.md
# sw_array_ctrl

Sequencing controller for a linear chain of `N_PE` Smith-Waterman PEs.
- Buffers one short read of `N_PE` bases, then broadcasts it into the chain using the single-pulse store token.
- Streams a reference sequence into PE0 with `init` asserted and zero boundary V/F values.
- Collects the last PE's column scores and reports the best score and its reference position.
- Sits between the host-side read/reference streams and the head/tail of the systolic array.

## Interface
Parameters:
- `N_PE`, 8, number of PEs in the chain; also the short-read length.
- `SCORE_W`, 10, width of V/F scores; must match the PE.
- `REF_LEN_W`, 16, width of the reference length and position.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a job; sampled only in IDLE.
- `ref_len`  in  REF_LEN_W  reference length; latched on an accepted `start`.
- `busy`  out  1  high in every state other than IDLE.
- `rd_base`, `rd_valid`  in  2, 1  short-read base stream.
- `rd_ready`  out  1  read-stream ready.
- `ref_base`, `ref_valid`  in  2, 1  reference base stream.
- `ref_ready`  out  1  reference-stream ready.
- `pe_S`  out  2  broadcast S bus to all PEs.
- `pe_store_S`  out  1  store token to PE0.
- `pe_T`  out  2  T input to PE0.
- `pe_init`  out  1  init input to PE0.
- `pe_V`, `pe_F`  out  SCORE_W  boundary inputs to PE0; always 0.
- `last_V`  in  SCORE_W  V_out of the last PE.
- `last_init`  in  1  init_out of the last PE.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  job aborted; held until the next `start`.
- `best_score`  out  SCORE_W  maximum `last_V` seen.
- `best_pos`  out  REF_LEN_W  0-based reference index of `best_score`.

## Operation
States: IDLE → LOAD → BCAST → STREAM → DRAIN → DONE → IDLE.
- **IDLE**
  - `start=1`, `ref_len≠0` → LOAD.
  - `start=1`, `ref_len=0` → DONE, with best=0 and no PE activity.
  - Accepting `start` clears `best_score`, `best_pos`, `err` and all counters.
  - `start` outside IDLE is ignored.
- **LOAD**
  - `rd_ready=1`; each `rd_valid&rd_ready` beat writes `buf[k]`, k=0..N_PE-1. Gaps are allowed.
  - After beat N_PE-1 → BCAST.
- **BCAST** (N_PE cycles, b=0..N_PE-1)
  - `pe_S=buf[b]`.
  - `pe_store_S=1` only at b=0. The token propagates one PE per cycle, so PE k captures `buf[k]`.
  - After b=N_PE-1 → STREAM.
- **STREAM**
  - `ref_ready=1`. Each accepted beat j is driven next cycle as `pe_T=ref_base`, `pe_init=1`.
  - The chain has no stall, so beats must be contiguous. `ref_valid=0` in any STREAM cycle is an underrun:
    - set `err`;
    - drive `pe_init=0` next cycle;
    - go to DONE.
  - After beat `ref_len-1` → DRAIN.
- **DRAIN**
  - `pe_init=0`, `pe_T=0`.
  - Result tracking runs in STREAM and DRAIN: each cycle with `last_init=1` is result r, counted 0.., with `last_V` as its score.
  - Update `best` when `last_V > best_score` (unsigned, strict); ties keep the earliest position.
  - When r reaches `ref_len-1` → DONE.
  - A timeout counter starts at DRAIN entry. If `N_PE+4` cycles pass without completion: set `err`, go to DONE.
- **DONE**
  - `done=1` for one cycle → IDLE.
  - `best_score`, `best_pos`, `err` hold until the next accepted `start`.

## Timing
- All outputs are registered. Reset values:
  - all outputs 0, state IDLE;
  - `rd_ready`, `ref_ready` low.
- `rst` asserted mid-job aborts immediately: outputs 0, no `done` pulse; buffer contents are don't-care.
- LOAD→BCAST: `pe_store_S` rises the cycle after the last read beat.
- BCAST→STREAM: `ref_ready` rises the cycle after BCAST b=N_PE-1. First `pe_init=1` is the cycle after the first accepted beat.
- Expected chain latency: `pe_init` to `last_init` = N_PE cycles. Results are taken whenever `last_init` is high, not at a fixed offset.
- `done` arrives 1 cycle after the final result cycle.
- With `ref_len=0`: `done` 2 cycles after `start`.
- `pe_V` and `pe_F` are 0 in all states.

## Test plan
- **Load with gaps.** N_PE=4; read 00,01,11,10 with `rd_valid` toggling → `pe_store_S` high exactly 1 cycle; `pe_S` = 00,01,11,10 on 4 consecutive cycles starting that cycle.
- **Contiguous stream.** `ref_len=5`, bases 00,01,00,10,00 → `pe_init` high exactly 5 consecutive cycles; `pe_T` mirrors the bases; `ref_ready` low after 5 beats; `pe_V=pe_F=0` throughout.
- **Best tracking.** Bench tail returns `last_init` with `last_V` = 3,7,7,2,5 → `done` pulse; `best_score=7`, `best_pos=1`, `err=0`.
- **Underrun.** `ref_valid` drops on the 3rd STREAM beat → `err=1`; `pe_init` low next cycle; `done` pulse; back to IDLE. **Timeout.** Tail never returns `last_init` → `err=1` and `done` N_PE+4 cycles after DRAIN entry.
- **Zero length.** `start` with `ref_len=0` → `done` 2 cycles later; `best_score=0`; `rd_ready`, `pe_store_S`, `pe_init` never asserted.
- **Reset mid-job.** `rst` during STREAM → all outputs 0 within the reset cycle, `busy=0`. **Ignored start.** `start` while busy is ignored. **Recovery.** A new job after reset completes with correct `best_score`/`best_pos`.
